// File: rtl/student_iic_ctrl_reg_pkg.sv
// Register map, access types and hw interface structs of the IIC control block.
package student_iic_ctrl_reg_pkg;

    localparam int unsigned BlockAw = 4;
    localparam int unsigned NumRegs = 4;

    localparam logic [BlockAw-1:0] STUDENT_IIC_CTRL_SDA_EN_OFFSET   = 4'h0;
    localparam logic [BlockAw-1:0] STUDENT_IIC_CTRL_SCL_EN_OFFSET   = 4'h4;
    localparam logic [BlockAw-1:0] STUDENT_IIC_CTRL_SDA_READ_OFFSET = 4'h8;
    localparam logic [BlockAw-1:0] STUDENT_IIC_CTRL_SCL_READ_OFFSET = 4'hc;

    typedef enum logic {
        AccRw = 1'b0,
        AccRo = 1'b1
    } access_e;

    localparam logic [BlockAw-1:0] RegOffsets [NumRegs] = '{
        STUDENT_IIC_CTRL_SDA_EN_OFFSET,
        STUDENT_IIC_CTRL_SCL_EN_OFFSET,
        STUDENT_IIC_CTRL_SDA_READ_OFFSET,
        STUDENT_IIC_CTRL_SCL_READ_OFFSET
    };

    localparam access_e RegAccess [NumRegs] = '{AccRw, AccRw, AccRo, AccRo};

    typedef struct packed {
        logic q;
        logic qe;
    } student_iic_ctrl_reg2hw_en_reg_t;

    typedef struct packed {
        student_iic_ctrl_reg2hw_en_reg_t sda_en;
        student_iic_ctrl_reg2hw_en_reg_t scl_en;
    } student_iic_ctrl_reg2hw_t;

    typedef struct packed {
        logic d;
    } student_iic_ctrl_hw2reg_read_reg_t;

    typedef struct packed {
        student_iic_ctrl_hw2reg_read_reg_t sda_read;
        student_iic_ctrl_hw2reg_read_reg_t scl_read;
    } student_iic_ctrl_hw2reg_t;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcode constants shared by register blocks.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AIW = 8;

    // A-channel opcodes
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    // D-channel opcodes
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DW-1:0]  a_data;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              a_ready;
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
    } tl_d2h_t;

endpackage

// File: rtl/student_iic_ctrl_subreg.sv
// 1-bit software-writable register with a registered write strobe.
// Ports: clk_i, rst_ni (async active-low), we/wd write strobe and data,
//        q register value, qe one-cycle pulse aligned with the updated q.
module student_iic_ctrl_subreg #(
    parameter logic RESVAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic we,
    input  logic wd,
    output logic q,
    output logic qe
);

    // Value and strobe update on the same edge so qe marks the new q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q  <= RESVAL;
            qe <= 1'b0;
        end else begin
            qe <= we;
            if (we) begin
                q <= wd;
            end
        end
    end

endmodule

// File: rtl/student_iic_ctrl_reg_top.sv
// TL-UL register block for the IIC controller: two RW enables, two RO pin reads.
// Ports: clk_i, rst_ni (async active-low), tl_i/tl_o TL-UL device port,
//        reg2hw enable values + strobes, hw2reg pin samples,
//        devmode_i selects error responses for unmapped/illegal accesses.
// Build option: STUDENT_IIC_CTRL_RO_WR_ERR_EN makes writes to RO registers error.
module student_iic_ctrl_reg_top
    import tlul_pkg::*;
    import student_iic_ctrl_reg_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  tl_h2d_t                  tl_i,
    output tl_d2h_t                  tl_o,
    output student_iic_ctrl_reg2hw_t reg2hw,
    input  student_iic_ctrl_hw2reg_t hw2reg,
    input  logic                     devmode_i
);

    typedef enum logic {
        StIdle = 1'b0,
        StRsp  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   accept;

    logic [NumRegs-1:0] addr_hit;
    logic               is_get, is_put, op_ok, mapped, ro_hit;
    logic               rd_bit, ro_wr_err;
    logic               rsp_err_d;
    logic [TL_DW-1:0]   rsp_data_d;
    logic [2:0]         rsp_op_d;

    logic               rsp_err_q;
    logic [TL_DW-1:0]   rsp_data_q;
    logic [2:0]         rsp_op_q;
    logic [TL_SZW-1:0]  rsp_size_q;
    logic [TL_AIW-1:0]  rsp_source_q;

    logic sda_we, scl_we;

    // Transaction state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One outstanding transaction: accept only while no response is pending.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tl_i.a_valid) begin
                    accept  = 1'b1;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (tl_i.d_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address/opcode decode and response formation
    always_comb begin
        addr_hit = '0;
        ro_hit   = 1'b0;
        for (int i = 0; i < int'(NumRegs); i++) begin
            addr_hit[i] = (tl_i.a_address[BlockAw-1:2] == RegOffsets[i][BlockAw-1:2]);
            if (addr_hit[i] && (RegAccess[i] == AccRo)) begin
                ro_hit = 1'b1;
            end
        end
        mapped = |addr_hit;
        is_get = (tl_i.a_opcode == Get);
        is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
        op_ok  = is_get || is_put;

        rd_bit = 1'b0;
        if (addr_hit[0]) rd_bit = reg2hw.sda_en.q;
        if (addr_hit[1]) rd_bit = reg2hw.scl_en.q;
        if (addr_hit[2]) rd_bit = hw2reg.sda_read.d;
        if (addr_hit[3]) rd_bit = hw2reg.scl_read.d;

`ifdef STUDENT_IIC_CTRL_RO_WR_ERR_EN
        ro_wr_err = is_put && ro_hit;
`else
        ro_wr_err = 1'b0;
`endif

        rsp_err_d  = (!op_ok || !mapped) ? devmode_i : ro_wr_err;
        rsp_data_d = (is_get && mapped) ? TL_DW'(rd_bit) : '0;
        rsp_op_d   = is_get ? AccessAckData : AccessAck;
    end

    // Response payload captured on acceptance, held until consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            rsp_op_q     <= AccessAck;
            rsp_size_q   <= '0;
            rsp_source_q <= '0;
        end else if (accept) begin
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            rsp_op_q     <= rsp_op_d;
            rsp_size_q   <= tl_i.a_size;
            rsp_source_q <= tl_i.a_source;
        end
    end

    assign sda_we = accept && is_put && addr_hit[0] && tl_i.a_mask[0];
    assign scl_we = accept && is_put && addr_hit[1] && tl_i.a_mask[0];

    student_iic_ctrl_subreg #(.RESVAL(1'b0)) u_sda_en (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (sda_we),
        .wd     (tl_i.a_data[0]),
        .q      (reg2hw.sda_en.q),
        .qe     (reg2hw.sda_en.qe)
    );

    student_iic_ctrl_subreg #(.RESVAL(1'b0)) u_scl_en (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (scl_we),
        .wd     (tl_i.a_data[0]),
        .q      (reg2hw.scl_en.q),
        .qe     (reg2hw.scl_en.qe)
    );

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (state_q == StIdle);
        tl_o.d_valid  = (state_q == StRsp);
        tl_o.d_opcode = rsp_op_q;
        tl_o.d_data   = rsp_data_q;
        tl_o.d_error  = rsp_err_q;
        tl_o.d_size   = rsp_size_q;
        tl_o.d_source = rsp_source_q;
    end

    // Address bits above the block, byte lanes and data bits beyond bit 0 are don't-care.
    logic unused_tl;
    assign unused_tl = ^{tl_i.a_address[TL_AW-1:BlockAw], tl_i.a_address[1:0],
                         tl_i.a_data[TL_DW-1:1], tl_i.a_mask[TL_DBW-1:1]};

endmodule

// File: tb/tb_student_iic_ctrl_reg_top.sv
// Self-checking bench for student_iic_ctrl_reg_top: directed register-map
// steps followed by randomized transactions against a behavioural model.
module tb_student_iic_ctrl_reg_top;
    import tlul_pkg::*;
    import student_iic_ctrl_reg_pkg::*;

`ifdef STUDENT_IIC_CTRL_RO_WR_ERR_EN
    localparam bit RoWrErr = 1'b1;
`else
    localparam bit RoWrErr = 1'b0;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    tl_h2d_t                  tl_i;
    tl_d2h_t                  tl_o;
    student_iic_ctrl_reg2hw_t reg2hw;
    student_iic_ctrl_hw2reg_t hw2reg;
    logic                     devmode_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the two writable enables
    bit m_sda = 1'b0;
    bit m_scl = 1'b0;

    always #5 clk_i = ~clk_i;

    student_iic_ctrl_reg_top dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .tl_i      (tl_i),
        .tl_o      (tl_o),
        .reg2hw    (reg2hw),
        .hw2reg    (hw2reg),
        .devmode_i (devmode_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; response is held 'hold' cycles with an intruding request.
    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold);
        logic [31:0] e_data;
        logic [2:0]  e_op;
        logic        e_err, e_sda_qe, e_scl_qe;
        logic [7:0]  src;
        logic [1:0]  sz;
        int unsigned idx;
        bit          get, put;

        src = 8'($urandom);
        sz  = 2'($urandom);
        @(negedge clk_i);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = wdata;
        tl_i.a_mask    = mask;
        tl_i.a_size    = sz;
        tl_i.a_source  = src;
        tl_i.d_ready   = 1'b0;
        chk("a_ready_idle", 32'(tl_o.a_ready), 32'd1);

        // Expected outcome from the register map rules
        idx = 32'(addr[3:0]) / 4;
        get = (op == 3'h4);
        put = (op == 3'h0) || (op == 3'h1);
        e_sda_qe = 1'b0;
        e_scl_qe = 1'b0;
        e_data   = 32'd0;
        e_op     = get ? 3'h1 : 3'h0;
        e_err    = 1'b0;
        if (!get && !put) begin
            e_err = devmode_i;
        end else if (get) begin
            case (idx)
                0: e_data = 32'(m_sda);
                1: e_data = 32'(m_scl);
                2: e_data = 32'(hw2reg.sda_read.d);
                default: e_data = 32'(hw2reg.scl_read.d);
            endcase
        end else begin
            if (idx >= 2) e_err = RoWrErr;
            else if (mask[0]) begin
                if (idx == 0) begin m_sda = wdata[0]; e_sda_qe = 1'b1; end
                else          begin m_scl = wdata[0]; e_scl_qe = 1'b1; end
            end
        end

        @(negedge clk_i);
        chk("d_valid", 32'(tl_o.d_valid), 32'd1);
        chk("d_opcode", 32'(tl_o.d_opcode), 32'(e_op));
        chk("d_data", tl_o.d_data, e_data);
        chk("d_error", 32'(tl_o.d_error), 32'(e_err));
        chk("d_source", 32'(tl_o.d_source), 32'(src));
        chk("d_size", 32'(tl_o.d_size), 32'(sz));
        chk("sda_q", 32'(reg2hw.sda_en.q), 32'(m_sda));
        chk("scl_q", 32'(reg2hw.scl_en.q), 32'(m_scl));
        chk("sda_qe", 32'(reg2hw.sda_en.qe), 32'(e_sda_qe));
        chk("scl_qe", 32'(reg2hw.scl_en.qe), 32'(e_scl_qe));
        tl_i.a_valid = 1'b0;

        for (int h = 0; h < hold; h++) begin
            tl_i.a_valid   = 1'b1;
            tl_i.a_opcode  = 3'h0;
            tl_i.a_address = 32'h0;
            tl_i.a_data    = 32'(~m_sda);
            tl_i.a_mask    = 4'hf;
            tl_i.a_source  = ~src;
            @(negedge clk_i);
            chk("hold_d_valid", 32'(tl_o.d_valid), 32'd1);
            chk("hold_d_data", tl_o.d_data, e_data);
            chk("hold_d_source", 32'(tl_o.d_source), 32'(src));
            chk("hold_a_ready", 32'(tl_o.a_ready), 32'd0);
            chk("hold_sda_qe", 32'(reg2hw.sda_en.qe), 32'd0);
            chk("hold_sda_q", 32'(reg2hw.sda_en.q), 32'(m_sda));
        end

        tl_i.d_ready = 1'b1;
        @(negedge clk_i);
        chk("done_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("done_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("done_sda_qe", 32'(reg2hw.sda_en.qe), 32'd0);
        chk("done_scl_qe", 32'(reg2hw.scl_en.qe), 32'd0);
        chk("done_sda_q", 32'(reg2hw.sda_en.q), 32'(m_sda));
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b0;
    endtask

    initial begin
        logic [2:0] op;
        tl_i      = '0;
        hw2reg    = '0;
        devmode_i = 1'b1;
        rst_ni    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("rst_d_error", 32'(tl_o.d_error), 32'd0);
        chk("rst_d_data", tl_o.d_data, 32'd0);
        chk("rst_sda_q", 32'(reg2hw.sda_en.q), 32'd0);
        chk("rst_scl_q", 32'(reg2hw.scl_en.q), 32'd0);
        chk("rst_qe", 32'({reg2hw.sda_en.qe, reg2hw.scl_en.qe}), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);

        // Reset reads
        txn(3'h4, 32'h0, 32'h0, 4'hf, 0);
        txn(3'h4, 32'h4, 32'h0, 4'hf, 0);
        // SDA_EN write and readback
        txn(3'h0, 32'h0, 32'h1, 4'hf, 0);
        txn(3'h4, 32'h0, 32'h0, 4'hf, 0);
        // SCL_EN written twice, second write clears
        txn(3'h0, 32'h4, 32'h1, 4'hf, 0);
        txn(3'h1, 32'h4, 32'h0, 4'h1, 0);
        // RO pin reads
        hw2reg.sda_read.d = 1'b1;
        hw2reg.scl_read.d = 1'b0;
        txn(3'h4, 32'h8, 32'h0, 4'hf, 0);
        txn(3'h4, 32'hc, 32'h0, 4'hf, 0);
        // Writes to RO registers, both devmode settings
        txn(3'h0, 32'h8, 32'h1, 4'hf, 0);
        devmode_i = 1'b0;
        txn(3'h0, 32'hc, 32'h1, 4'hf, 0);
        // Back-pressure with an intruding request
        txn(3'h4, 32'h0, 32'h0, 4'hf, 3);
        // Masked write is a no-op; same-value write still strobes
        txn(3'h0, 32'h4, 32'h1, 4'he, 0);
        txn(3'h0, 32'h0, 32'h1, 4'hf, 0);
        // Illegal opcode, both devmode settings; upper/low address bits ignored
        txn(3'h2, 32'h0, 32'h0, 4'hf, 0);
        devmode_i = 1'b1;
        txn(3'h7, 32'h4, 32'h1, 4'hf, 1);
        txn(3'h4, 32'hffff_fff3, 32'h0, 4'hf, 0);

        // Reset while a write response is pending
        @(negedge clk_i);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = 3'h0;
        tl_i.a_address = 32'h4;
        tl_i.a_data    = 32'h1;
        tl_i.a_mask    = 4'hf;
        @(negedge clk_i);
        tl_i.a_valid = 1'b0;
        rst_ni = 1'b0;
        m_sda = 1'b0;
        m_scl = 1'b0;
        #1;
        chk("midrst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("midrst_scl_q", 32'(reg2hw.scl_en.q), 32'd0);
        chk("midrst_scl_qe", 32'(reg2hw.scl_en.qe), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("postrst_d_valid", 32'(tl_o.d_valid), 32'd0);
        chk("postrst_a_ready", 32'(tl_o.a_ready), 32'd1);
        chk("postrst_qe", 32'({reg2hw.sda_en.qe, reg2hw.scl_en.qe}), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0: op = 3'h0;
                1: op = 3'h1;
                2: op = 3'h4;
                default: op = 3'($urandom);
            endcase
            devmode_i         = 1'($urandom);
            hw2reg.sda_read.d = 1'($urandom);
            hw2reg.scl_read.d = 1'($urandom);
            txn(op, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/student_iic_ctrl_reg_top.md
STUDENT_IIC_CTRL_REG_TOP -- requirements
Module: student_iic_ctrl_reg_top

Interface
REQ-001 Parameters: none; register map and widths are fixed by the package.
REQ-002 clk_i  input  1  clock, all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 tl_i  input  tlul_pkg::tl_h2d_t  TL-UL request (a_valid, a_opcode, a_address, a_data, a_mask, a_size, a_source, d_ready).
REQ-005 tl_o  output  tlul_pkg::tl_d2h_t  TL-UL response (a_ready, d_valid, d_opcode, d_data, d_error, d_size, d_source).
REQ-006 reg2hw  output  student_iic_ctrl_reg2hw_t  sda_en.{q,qe}, scl_en.{q,qe}, 1 bit each.
REQ-007 hw2reg  input  student_iic_ctrl_hw2reg_t  sda_read.d, scl_read.d, 1 bit each.
REQ-008 devmode_i  input  1  1 = error response for unmapped access.

Function
REQ-009 Map (byte offsets, 32-bit words, bit 0 only): 0x0 SDA_EN RW; 0x4 SCL_EN RW; 0x8 SDA_READ RO; 0xC SCL_READ RO.
REQ-010 Decode uses a_address[3:0]; a_address[1:0] ignored; upper bits ignored.
REQ-011 Request accepted when a_valid && a_ready; a_ready = !d_valid (one outstanding transaction).
REQ-012 Response: d_valid rises cycle after acceptance, holds until d_ready; d_source/d_size echo the request.
REQ-013 Get -> d_opcode AccessAckData; PutFullData/PutPartialData -> AccessAck.
REQ-014 Write to SDA_EN/SCL_EN with a_mask[0]=1 sets q = a_data[0] on the acceptance edge.
REQ-015 qe pulses high exactly one cycle, the cycle after acceptance, aligned with the updated q; qe pulses even when value is unchanged.
REQ-016 Write with a_mask[0]=0 leaves q unchanged, no qe, no error.
REQ-017 Read returns register value (or hw2reg.*.d sampled on acceptance cycle) in d_data[0]; d_data[31:1] = 0.
REQ-018 Reads have no side effects; qe never pulses on a read.
REQ-019 Unmapped address (none in 4-bit space; reserved for future growth) or a_opcode not Get/Put: d_error = devmode_i, no register change, d_data = 0.
REQ-020 Writes to SDA_READ/SCL_READ ignored; error per REQ-027.
REQ-021 Simultaneous d_ready and new a_valid: new request accepted no earlier than cycle after d_valid drops.

Reset
REQ-022 On rst_ni low: sda_en.q = 0, scl_en.q = 0, qe = 0, d_valid = 0, d_error = 0, d_data = 0.
REQ-023 After reset: a_ready = 1.
REQ-024 Reset mid-transaction discards the pending response; no qe issued afterwards.

Configuration
REQ-025 Macro STUDENT_IIC_CTRL_RO_WR_ERR_EN.
REQ-026 Not defined: writes to RO registers return d_error = 0.
REQ-027 Defined: writes to RO registers return d_error = 1 regardless of devmode_i.

Structure
REQ-028 Package student_iic_ctrl_reg_pkg holds reg2hw_t, hw2reg_t, BlockAw = 4, offset constants, and access-type constants.
REQ-029 Sub-module student_iic_ctrl_subreg: 1-bit RW flop with write-enable, write-data, reset value and registered qe; instantiated twice.

Verification
REQ-030 Reset, read 0x0 and 0x4 -> d_data = 0, d_error = 0, AccessAckData.
REQ-031 Write 0x1 to 0x0 -> sda_en.q = 1 and sda_en.qe high for exactly one cycle; scl_en.qe stays 0; readback 0x0 = 1.
REQ-032 Write 0x1 then 0x0 to 0x4 -> two qe pulses, scl_en.q ends 0.
REQ-033 hw2reg.sda_read.d = 1, scl_read.d = 0; read 0x8 -> 1, 0xC -> 0.
REQ-034 Write to 0x8 -> AccessAck, d_error = 0 without macro, 1 with macro, no reg2hw change.
REQ-035 Hold d_ready = 0 for 3 cycles -> d_valid and data stable, a_ready = 0, second request not accepted.
